// File: rtl/dc_ipu_filter_window.sv
// -----------------------------------------------------------------------------
// dc_ipu_filter_window
//
// Upstream feeder of the bicubic filter core. A 4x4 texel window is built from
// a stream of 4-texel columns. Each weight transaction first shifts in the
// requested number of columns, then emits one {weights_matrix, texel_matrix}
// beat. Advance 0 re-uses the window (upscale). Advance 2..3 skips columns
// (downscale).
//
// Ports
//   clk            rising-edge clock
//   clr            synchronous active-high reset
//   col_valid/col_ready/col_texels/col_sol
//                  column stream; col_texels[r] is window row r, and col_sol
//                  marks the first column of a source line
//   w_valid/w_ready/w_weights/w_advance
//                  weight stream; w_advance is the number of columns to shift
//                  in before the beat is emitted
//   out_valid/out_ready
//                  output beat handshake with the filter core
//   weights_matrix registered weights, [row][col]
//   texel_matrix   registered window, [row][col], col 3 newest
// -----------------------------------------------------------------------------
module dc_ipu_filter_window #(
   parameter int WEIGHT_WIDTH = 10,
   parameter int COLOR_WIDTH  = 8,
   parameter int ADV_WIDTH    = 2
) (
   input  logic                                   clk,
   input  logic                                   clr,
   input  logic                                   col_valid,
   output logic                                   col_ready,
   input  logic [0:3][COLOR_WIDTH-1:0]            col_texels,
   input  logic                                   col_sol,
   input  logic                                   w_valid,
   output logic                                   w_ready,
   input  logic [0:3][0:3][WEIGHT_WIDTH-1:0]      w_weights,
   input  logic [ADV_WIDTH-1:0]                   w_advance,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [0:3][0:3][WEIGHT_WIDTH-1:0]      weights_matrix,
   output logic [0:3][0:3][COLOR_WIDTH-1:0]       texel_matrix
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   state_t                                state_q, state_d;
   logic                                  primed_q, primed_d;
   logic [ADV_WIDTH-1:0]                  remaining_q, remaining_d;
   logic [0:3][0:3][COLOR_WIDTH-1:0]      win_q, win_d;
   logic [0:3][0:3][WEIGHT_WIDTH-1:0]     held_w_q, held_w_d;
   logic [0:3][0:3][WEIGHT_WIDTH-1:0]     wm_q, wm_d;
   logic [0:3][0:3][COLOR_WIDTH-1:0]      tm_q, tm_d;
   logic                                  out_valid_q, out_valid_d;

   logic                                  w_fire;
   logic                                  col_fire;
   logic                                  load;
   logic [ADV_WIDTH-1:0]                  adv_eff;

   // Readies depend on state only; forcing them low during clr makes sure no
   // handshake is reported in a cycle whose effects are discarded anyway.
   assign w_ready   = (state_q == S_IDLE)  && !clr;
   assign col_ready = (state_q == S_SHIFT) && !clr;

   assign w_fire   = w_valid   && w_ready;
   assign col_fire = col_valid && col_ready;

   // The output register may be (re)loaded when empty or when its current
   // beat is being taken this very cycle, which gives back-to-back beats.
   assign load = (state_q == S_EMIT) && (!out_valid_q || out_ready);

   // An unprimed window holds no real texels, so at least one column is
   // consumed before the first beat even when advance is 0.
   assign adv_eff = (primed_q || (w_advance != '0)) ? w_advance
                                                    : ADV_WIDTH'(1);

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      primed_d    = primed_q;
      remaining_d = remaining_q;
      win_d       = win_q;
      held_w_d    = held_w_q;
      wm_d        = wm_q;
      tm_d        = tm_q;
      out_valid_d = out_valid_q;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (w_fire) begin
               held_w_d    = w_weights;
               remaining_d = adv_eff;
               state_d     = (adv_eff == '0) ? S_EMIT : S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (col_fire) begin
               for (int r = 0; r < 4; r++) begin
                  if (col_sol) begin
                     // Start of a source line: replicate the edge column so
                     // the filter sees a clamped border.
                     for (int c = 0; c < 4; c++) begin
                        win_d[r][c] = col_texels[r];
                     end
                  end else begin
                     for (int c = 0; c < 3; c++) begin
                        win_d[r][c] = win_q[r][c+1];
                     end
                     win_d[r][3] = col_texels[r];
                  end
               end
               primed_d    = 1'b1;
               remaining_d = remaining_q - ADV_WIDTH'(1);
               if (remaining_q == ADV_WIDTH'(1)) begin
                  state_d = S_EMIT;
               end
            end
         end

         S_EMIT: begin
            if (load) begin
               tm_d        = win_q;
               wm_d        = held_w_q;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         primed_q    <= 1'b0;
         remaining_q <= '0;
         win_q       <= '0;
         held_w_q    <= '0;
         wm_q        <= '0;
         tm_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         primed_q    <= primed_d;
         remaining_q <= remaining_d;
         win_q       <= win_d;
         held_w_q    <= held_w_d;
         wm_q        <= wm_d;
         tm_q        <= tm_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign weights_matrix = wm_q;
   assign texel_matrix   = tm_q;

endmodule

// File: tb/tb_dc_ipu_filter_window.sv
// -----------------------------------------------------------------------------
// tb_dc_ipu_filter_window
//
// Directed and randomized bench for dc_ipu_filter_window. A reference model
// keeps the window as a plain 4x4 array and applies the column rules (shift or
// edge-replicate) per accepted column. Inputs are driven and outputs sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dc_ipu_filter_window;

   localparam int WW = 10;
   localparam int CW = 8;
   localparam int AW = 2;

   typedef logic [0:3][0:3][WW-1:0] wmat_t;
   typedef logic [0:3][0:3][CW-1:0] tmat_t;
   typedef logic [0:3][CW-1:0]      col_t;

   logic          clk = 1'b0;
   logic          clr;
   logic          col_valid;
   logic          col_ready;
   col_t          col_texels;
   logic          col_sol;
   logic          w_valid;
   logic          w_ready;
   wmat_t         w_weights;
   logic [AW-1:0] w_advance;
   logic          out_valid;
   logic          out_ready;
   wmat_t         weights_matrix;
   tmat_t         texel_matrix;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state.
   tmat_t m_win;
   bit    m_primed;

   dc_ipu_filter_window #(
      .WEIGHT_WIDTH (WW),
      .COLOR_WIDTH  (CW),
      .ADV_WIDTH    (AW)
   ) dut (
      .clk            (clk),
      .clr            (clr),
      .col_valid      (col_valid),
      .col_ready      (col_ready),
      .col_texels     (col_texels),
      .col_sol        (col_sol),
      .w_valid        (w_valid),
      .w_ready        (w_ready),
      .w_weights      (w_weights),
      .w_advance      (w_advance),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .weights_matrix (weights_matrix),
      .texel_matrix   (texel_matrix)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "simulation time limit exceeded");
   end

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_win    = '0;
      m_primed = 1'b0;
   endtask

   task automatic model_col(input col_t col, input bit sol);
      for (int r = 0; r < 4; r++) begin
         if (sol) begin
            for (int c = 0; c < 4; c++) m_win[r][c] = col[r];
         end else begin
            for (int c = 0; c < 3; c++) m_win[r][c] = m_win[r][c+1];
            m_win[r][3] = col[r];
         end
      end
      m_primed = 1'b1;
   endtask

   function automatic int cols_needed(input int adv);
      if (m_primed) return adv;
      return (adv == 0) ? 1 : adv;
   endfunction

   function automatic wmat_t rand_w();
      wmat_t w;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) w[r][c] = WW'($urandom);
      return w;
   endfunction

   function automatic col_t rand_col();
      col_t c;
      for (int r = 0; r < 4; r++) c[r] = CW'($urandom);
      return c;
   endfunction

   // Starts and ends on a falling edge; returns the column count the
   // transaction must consume according to the model.
   task automatic send_w(input wmat_t w, input int adv, output int need);
      int n;
      need      = cols_needed(adv);
      w_weights = w;
      w_advance = AW'(adv);
      w_valid   = 1'b1;
      n = 0;
      while (!w_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("w_handshake", {255'd0, w_ready}, 256'd1);
      @(negedge clk);
      w_valid = 1'b0;
   endtask

   task automatic send_col(input col_t col, input bit sol);
      int n;
      col_texels = col;
      col_sol    = sol;
      col_valid  = 1'b1;
      n = 0;
      while (!col_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("col_handshake", {255'd0, col_ready}, 256'd1);
      if (col_ready) model_col(col, sol);
      @(negedge clk);
      col_valid = 1'b0;
      col_sol   = 1'b0;
   endtask

   // Waits for a beat, checks it against the model, holds it for 'stall'
   // cycles checking it stays put, then takes it.
   task automatic expect_beat(input string tag, input wmat_t w, input int stall);
      int    n;
      tmat_t exp_t;
      exp_t = m_win;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, {255'd0, out_valid}, 256'd1);
      check({tag, "_weights"}, 256'(weights_matrix), 256'(w));
      check({tag, "_texels"}, 256'(texel_matrix), 256'(exp_t));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {255'd0, out_valid}, 256'd1);
         check({tag, "_hold_texels"}, 256'(texel_matrix), 256'(exp_t));
         check({tag, "_hold_weights"}, 256'(weights_matrix), 256'(w));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drained"}, {255'd0, out_valid}, 256'd0);
   endtask

   initial begin
      wmat_t wa, wb, wc;
      tmat_t ta, tb;
      col_t  col;
      int    need;
      int    adv;

      clr        = 1'b1;
      col_valid  = 1'b0;
      col_texels = '0;
      col_sol    = 1'b0;
      w_valid    = 1'b0;
      w_weights  = '0;
      w_advance  = '0;
      out_ready  = 1'b0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_out_valid", {255'd0, out_valid}, 256'd0);
      check("rst_w_ready", {255'd0, w_ready}, 256'd0);
      check("rst_col_ready", {255'd0, col_ready}, 256'd0);
      check("rst_texels", 256'(texel_matrix), 256'd0);
      check("rst_weights", 256'(weights_matrix), 256'd0);
      clr = 1'b0;
      @(negedge clk);
      check("idle_w_ready", {255'd0, w_ready}, 256'd1);

      // 1: unprimed advance 0 still consumes one column (edge replicated).
      wa = rand_w();
      send_w(wa, 0, need);
      check("t1_need", 256'(need), 256'd1);
      check("t1_col_ready", {255'd0, col_ready}, 256'd1);
      send_col({8'd10, 8'd20, 8'd30, 8'd40}, 1'b1);
      check("t1_col_done", {255'd0, col_ready}, 256'd0);
      check("t1_model", 256'(m_win),
            256'({ {4{8'd10}}, {4{8'd20}}, {4{8'd30}}, {4{8'd40}} }));
      expect_beat("t1", wa, 0);

      // 2: advance 1 shifts in one new column at col 3.
      wa = rand_w();
      send_w(wa, 1, need);
      send_col({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);
      check("t2_col_done", {255'd0, col_ready}, 256'd0);
      expect_beat("t2", wa, 1);

      // 3: advance 0 twice re-uses the window with new weights.
      wa = rand_w();
      wb = rand_w();
      send_w(wa, 0, need);
      check("t3a_no_col", {255'd0, col_ready}, 256'd0);
      expect_beat("t3a", wa, 0);
      send_w(wb, 0, need);
      check("t3b_no_col", {255'd0, col_ready}, 256'd0);
      expect_beat("t3b", wb, 0);

      // 4: back-pressure with two weight sets queued.
      wa = rand_w();
      wb = rand_w();
      send_w(wa, 1, need);
      send_col(rand_col(), 1'b0);
      ta = m_win;
      send_w(wb, 1, need);
      send_col(rand_col(), 1'b0);
      tb = m_win;
      col_texels = rand_col();
      col_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_hold_valid", {255'd0, out_valid}, 256'd1);
         check("t4_hold_weights", 256'(weights_matrix), 256'(wa));
         check("t4_hold_texels", 256'(texel_matrix), 256'(ta));
         check("t4_w_ready", {255'd0, w_ready}, 256'd0);
         check("t4_col_ready", {255'd0, col_ready}, 256'd0);
      end
      col_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_b_valid", {255'd0, out_valid}, 256'd1);
      check("t4_b_weights", 256'(weights_matrix), 256'(wb));
      check("t4_b_texels", 256'(texel_matrix), 256'(tb));
      @(negedge clk);
      out_ready = 1'b0;
      check("t4_drained", {255'd0, out_valid}, 256'd0);

      // 5: advance 3 shifts three columns.
      wc = rand_w();
      ta = m_win;
      send_w(wc, 3, need);
      check("t5_need", 256'(need), 256'd3);
      for (int i = 0; i < 3; i++) send_col(rand_col(), 1'b0);
      for (int r = 0; r < 4; r++)
         check("t5_old_col3", 256'(m_win[r][0]), 256'(ta[r][3]));
      expect_beat("t5", wc, 0);

      // 6: clr in SHIFT with remaining 2.
      wa = rand_w();
      send_w(wa, 2, need);
      check("t6_in_shift", {255'd0, col_ready}, 256'd1);
      clr = 1'b1;
      @(negedge clk);
      check("t6_out_valid", {255'd0, out_valid}, 256'd0);
      check("t6_texels", 256'(texel_matrix), 256'd0);
      check("t6_weights", 256'(weights_matrix), 256'd0);
      check("t6_col_ready", {255'd0, col_ready}, 256'd0);
      clr = 1'b0;
      model_reset();
      @(negedge clk);
      check("t6_idle", {255'd0, w_ready}, 256'd1);
      wa = rand_w();
      send_w(wa, 0, need);
      check("t6_col_ready_after_w", {255'd0, col_ready}, 256'd1);
      send_col(rand_col(), 1'b0);
      check("t6_col_done", {255'd0, col_ready}, 256'd0);
      expect_beat("t6", wa, 0);

      // Randomized transactions against the model.
      for (int k = 0; k < 40; k++) begin
         adv = int'($urandom_range(0, 3));
         wa  = rand_w();
         send_w(wa, adv, need);
         check("rnd_col_ready_after_w", {255'd0, col_ready},
               (need != 0) ? 256'd1 : 256'd0);
         for (int i = 0; i < need; i++) begin
            col = rand_col();
            send_col(col, $urandom_range(0, 7) == 0);
         end
         check("rnd_col_done", {255'd0, col_ready}, 256'd0);
         expect_beat("rnd", wa, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
